serial_adder: RTL

//   Bit-serial ripple adder built around the existing 1-bit fulladder cell.

---
 rtl/serial_adder_pkg.sv | 28 ++
 rtl/serial_adder_fulladder.sv | 16 +
 rtl/serial_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// width limits and the counter sizing helper.
package serial_adder_pkg;

  // Default and legal operand widths
  localparam int unsigned SA_WIDTH_DEFAULT = 8;
  localparam int unsigned SA_WIDTH_MIN     = 2;
  localparam int unsigned SA_WIDTH_MAX     = 32;

  // Controller states; DONE lasts exactly one cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

  // Bit-index counter width: enough to hold 0..width-1
  function automatic int unsigned sa_cnt_width(input int unsigned width);
    int unsigned w;
    if (width < SA_WIDTH_MIN) begin
      w = 1;
    end else begin
      w = $clog2(width);
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell used as the arithmetic core of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign sum   = w_axb ^ cin;
  assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit pair per clock, LSB first, through a
// single full-adder cell. Result and carry-out are registered and held
// until the next completion, with a one-cycle done strobe.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned          CNT_W    = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e          r_state;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  // Partial-sum shifter keeps only the upper WIDTH-1 bits: the lowest bit
  // of a full-width shifter would be shifted out before it is ever read.
  logic [WIDTH-2:0]   r_s_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_s;
  logic               w_co;
  logic [WIDTH-1:0]   w_sum_next;
  logic               w_last_bit;

  // Full-adder cell on the current LSB pair and the stored carry
  fulladder u_fa (r_a_sr[0], r_b_sr[0], r_carry, w_s, w_co);

  // New sum bit enters at the top; after the last bit this is the full result
  assign w_sum_next = {w_s, r_s_sr};
  assign w_last_bit = (r_count == CNT_LAST);

  // Controller, datapath shifters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sr  <= {WIDTH{1'b0}};
      r_b_sr  <= {WIDTH{1'b0}};
      r_s_sr  <= {(WIDTH-1){1'b0}};
      r_carry <= 1'b0;
      r_count <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_count <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_s_sr  <= w_sum_next[WIDTH-1:1];
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_carry <= w_co;
          r_count <= r_count + CNT_ONE;
          if (w_last_bit) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
